// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the control unit and the multiply/divide unit
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divZero;

    modport master (output start, op, srcA, srcB, input busy, done, hi, lo, divZero);
    modport slave  (input start, op, srcA, srcB, output busy, done, hi, lo, divZero);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU producing HI/LO, one bit per cycle
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state, state_next;
    logic                 is_div, neg_q, sign_a, done_q, dz_q;
    logic [WIDTH-1:0]     a_raw, b_mag, rem, hi_q, lo_q;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 sa_in, sb_in, ge;
    logic [WIDTH-1:0]     a_in, b_in, quo, rmd;
    logic [WIDTH:0]       msum, shifted, diff;
    logic [2*WIDTH-1:0]   prod;

    // Operand sign handling, one iteration step for each algorithm, and final sign fix-up
    always_comb begin
        sa_in   = bus.op[0] & bus.srcA[WIDTH-1];
        sb_in   = bus.op[0] & bus.srcB[WIDTH-1];
        a_in    = sa_in ? -bus.srcA : bus.srcA;
        b_in    = sb_in ? -bus.srcB : bus.srcB;
        msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_mag & {WIDTH{acc[0]}}};
        shifted = {rem, acc[WIDTH-1]};
        diff    = shifted - {1'b0, b_mag};
        ge      = ~diff[WIDTH];
        prod    = neg_q ? -acc : acc;
        quo     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rmd     = sign_a ? -rem : rem;
    end

    // Next state: accept in IDLE, WIDTH iterations in CALC, one fix-up cycle
    always_comb begin
        state_next = (state == IDLE) ? (bus.start ? CALC : IDLE) :
                     (state == CALC) ? ((cnt == CW'(WIDTH - 1)) ? FIX : CALC) : IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Datapath: latch magnitudes, iterate, then publish HI/LO with a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            cnt    <= '0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE && bus.start) begin
                is_div <= bus.op[1];
                neg_q  <= sa_in ^ sb_in;
                sign_a <= sa_in;
                a_raw  <= bus.srcA;
                b_mag  <= b_in;
                acc    <= {{WIDTH{1'b0}}, a_in};
                rem    <= '0;
                cnt    <= '0;
            end else if (state == CALC) begin
                cnt <= cnt + CW'(1);
                if (is_div) begin
                    rem              <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ge};
                end else begin
                    acc <= {msum, acc[WIDTH-1:1]};
                end
            end else if (state == FIX) begin
                done_q <= 1'b1;
                if (is_div && b_mag == '0) begin
                    hi_q <= a_raw;
                    lo_q <= '1;
                    dz_q <= 1'b1;
                end else begin
                    hi_q <= is_div ? rmd : prod[2*WIDTH-1:WIDTH];
                    lo_q <= is_div ? quo : prod[WIDTH-1:0];
                    dz_q <= 1'b0;
                end
            end
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.divZero = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table, handshake corner cases and random ops against an arithmetic model
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [64:0] last = '0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // {divZero, hi, lo} straight from the arithmetic definition of each op
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'd0) return {1'b0, {32'b0, a} * {32'b0, b}};
        if (op == 2'd1) return {1'b0, 64'(sa * sb)};
        if (b == 0)     return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'd2) return {1'b0, a % b, a / b};
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srcA  = a;
        bus.srcB  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.srcA  = $urandom;
        bus.srcB  = $urandom;
    endtask

    // Follows one operation from cycle 1 after the accept edge; returns during the done cycle
    task automatic finish_op(input string name, input logic [64:0] exp, input int glitch_at, input int rst_at);
        int busy_n = 0;
        int done_c = 0;
        int late_done = 0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_c = c;
                break;
            end
            if (c == 33) check({name, "_hold"}, {bus.divZero, bus.hi, bus.lo}, last);
            if (c == glitch_at) begin
                bus.start = 1'b1;
                bus.op    = 2'b10;
                bus.srcA  = $urandom;
                bus.srcB  = $urandom;
            end
            if (c == rst_at) rst = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (c == rst_at) begin
                @(posedge clk);
                #1;
                rst = 1'b0;
                check({name, "_cleared"}, {bus.busy, bus.done, bus.divZero, bus.hi, bus.lo}, '0);
                last = '0;
                for (int k = 0; k < 40; k++) begin
                    if (bus.done || bus.busy) late_done++;
                    @(posedge clk);
                    #1;
                end
                check({name, "_no_done"}, 65'(late_done), '0);
                return;
            end
        end
        check({name, "_done_cycle"}, 65'(done_c), 65'd34);
        check({name, "_busy_cycles"}, 65'(busy_n), 65'd33);
        if (done_c != 0) check({name, "_result"}, {bus.divZero, bus.hi, bus.lo}, exp);
        last = exp;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[3] = '{2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        vecs[5] = '{2'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{2'd0, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
        vecs[7] = '{2'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[8] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
        vecs[9] = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.srcA  = '0;
        bus.srcB  = '0;
        idle(2);
        rst = 1'b0;
        check("reset", {bus.busy, bus.done, bus.divZero, bus.hi, bus.lo}, '0);

        for (int i = 0; i < 10; i++) begin
            idle(i % 2);
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            finish_op($sformatf("vec%0d", i), {vecs[i].dz, vecs[i].hi, vecs[i].lo}, 0, 0);
        end

        idle(1);
        start_op(2'd0, 32'd1234, 32'd5678);
        finish_op("start_in_calc", {1'b0, 64'd7006652}, 5, 0);
        start_op(2'd1, 32'hFFFF_0000, 32'd99);
        finish_op("b2b", {1'b0, 64'hFFFF_FFFF_FF9D_0000}, 0, 0);

        start_op(2'd3, 32'd1000, 32'd3);
        finish_op("rst_mid", '0, 0, 10);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 3) == 0) b = -b;
            idle($urandom_range(0, 2));
            start_op(op, a, b);
            finish_op($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), model(op, a, b), 0, 0);
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
